// File: rtl/crop_writer.sv
// crop_writer: takes one full AXI-Stream frame per ap_start and forwards only the
// OUT_ROWS x OUT_COLS window at (row_offset, col_offset), in raster order, through a
// single output register.
module crop_writer #(
  parameter int unsigned IN_ROWS  = 32,
  parameter int unsigned IN_COLS  = 32,
  parameter int unsigned OUT_ROWS = 10,
  parameter int unsigned OUT_COLS = 10
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       ap_start,
  output logic                       ap_ready,
  output logic                       ap_idle,
  output logic                       ap_done,
  input  logic [$clog2(IN_ROWS)-1:0] row_offset,
  input  logic [$clog2(IN_COLS)-1:0] col_offset,
  output logic                       cfg_err,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [7:0]                 s_axis_tdata,
  input  logic                       s_axis_tuser,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [7:0]                 m_axis_tdata,
  output logic                       m_axis_tlast
);

  localparam int unsigned OffRW = $clog2(IN_ROWS);
  localparam int unsigned OffCW = $clog2(IN_COLS);
  localparam int unsigned RowW  = OffRW + 1;
  localparam int unsigned ColW  = OffCW + 1;
  localparam int unsigned OutN  = OUT_ROWS * OUT_COLS;
  localparam int unsigned CntW  = $clog2(OutN) + 1;

  typedef enum logic [1:0] {StIdle, StWaitSof, StCrop, StDrain} state_e;

  state_e           state_q, state_d;
  logic [OffRW-1:0] row_off_q, row_off_d;
  logic [OffCW-1:0] col_off_q, col_off_d;
  logic [RowW-1:0]  in_row_q, in_row_d;
  logic [ColW-1:0]  in_col_q, in_col_d;
  logic [CntW-1:0]  out_cnt_q, out_cnt_d;
  logic             cfg_err_q, cfg_err_d;
  logic             done_q, done_d;
  logic             valid_q, last_q;
  logic [7:0]       data_q;

  logic [RowW-1:0]  cur_row;
  logic [ColW-1:0]  cur_col;
  logic [CntW-1:0]  cur_cnt;
  logic             sof_pos;
  logic             in_win;
  logic             bad_cfg;
  logic             out_free;
  logic             beat_ok;
  logic             accept;
  logic             load;

  // Position of the beat currently on the input: a tuser beat is always pixel (0,0).
  always_comb begin
    sof_pos = s_axis_tuser || (state_q == StWaitSof);
    cur_row = sof_pos ? '0 : in_row_q;
    cur_col = sof_pos ? '0 : in_col_q;
    cur_cnt = sof_pos ? '0 : out_cnt_q;
    // Widened 32-bit compares so offset+size never wraps.
    in_win  = (32'(cur_row) >= 32'(row_off_q)) && (32'(cur_row) < 32'(row_off_q) + OUT_ROWS) &&
              (32'(cur_col) >= 32'(col_off_q)) && (32'(cur_col) < 32'(col_off_q) + OUT_COLS);
    bad_cfg = (32'(row_offset) + OUT_ROWS > IN_ROWS) || (32'(col_offset) + OUT_COLS > IN_COLS);
    out_free = !valid_q || m_axis_tready;
  end

  // Next-state, counters and handshake.
  always_comb begin
    state_d       = state_q;
    row_off_d     = row_off_q;
    col_off_d     = col_off_q;
    in_row_d      = in_row_q;
    in_col_d      = in_col_q;
    out_cnt_d     = out_cnt_q;
    cfg_err_d     = cfg_err_q;
    done_d        = 1'b0;
    s_axis_tready = 1'b0;
    beat_ok       = 1'b0;
    load          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ap_start) begin
          row_off_d = row_offset;
          col_off_d = col_offset;
          cfg_err_d = bad_cfg;
          in_row_d  = '0;
          in_col_d  = '0;
          out_cnt_d = '0;
          if (bad_cfg) done_d = 1'b1;
          else         state_d = StWaitSof;
        end
      end
      StWaitSof: begin
        // Output register is always empty here, so no stall is needed.
        s_axis_tready = 1'b1;
        beat_ok       = s_axis_tuser;
      end
      StCrop: begin
        s_axis_tready = in_win ? out_free : 1'b1;
        beat_ok       = 1'b1;
      end
      StDrain: begin
        if (out_free) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
    endcase

    accept = s_axis_tvalid && s_axis_tready && beat_ok;

    if (accept) begin
      if (cur_col == ColW'(IN_COLS - 1)) begin
        in_col_d = '0;
        in_row_d = cur_row + RowW'(1);
      end else begin
        in_col_d = cur_col + ColW'(1);
        in_row_d = cur_row;
      end
      out_cnt_d = cur_cnt;
      if (in_win) begin
        load      = 1'b1;
        out_cnt_d = cur_cnt + CntW'(1);
      end
      // tuser anywhere but (0,0) is a resync.
      if (state_q == StCrop && s_axis_tuser && (in_row_q != '0 || in_col_q != '0)) begin
        cfg_err_d = 1'b1;
      end
      if (cur_row == RowW'(IN_ROWS - 1) && cur_col == ColW'(IN_COLS - 1)) state_d = StDrain;
      else if (state_q == StWaitSof)                                      state_d = StCrop;
    end
  end

  // Control state and counters.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= StIdle;
      row_off_q <= '0;
      col_off_q <= '0;
      in_row_q  <= '0;
      in_col_q  <= '0;
      out_cnt_q <= '0;
      cfg_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_off_q <= row_off_d;
      col_off_q <= col_off_d;
      in_row_q  <= in_row_d;
      in_col_q  <= in_col_d;
      out_cnt_q <= out_cnt_d;
      cfg_err_q <= cfg_err_d;
      done_q    <= done_d;
    end
  end

  // Single output register: reload wins over drain, data held while stalled.
  always_ff @(posedge clk) begin
    if (srst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= s_axis_tdata;
      last_q  <= (cur_cnt == CntW'(OutN - 1));
    end else if (valid_q && m_axis_tready) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  // Output mapping.
  always_comb begin
    ap_ready      = (state_q == StIdle);
    ap_idle       = (state_q == StIdle);
    ap_done       = done_q;
    cfg_err       = cfg_err_q;
    m_axis_tvalid = valid_q;
    m_axis_tdata  = data_q;
    m_axis_tlast  = last_q;
  end

endmodule

// File: tb/tb_crop_writer.sv
// tb_crop_writer: directed frames through an 8x8 -> 3x3 crop_writer.
module tb_crop_writer;

  logic       clk = 1'b0;
  logic       srst;
  logic       ap_start;
  logic       ap_ready, ap_idle, ap_done;
  logic [2:0] row_offset, col_offset;
  logic       cfg_err;
  logic       s_axis_tvalid, s_axis_tready, s_axis_tuser;
  logic [7:0] s_axis_tdata;
  logic       m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [7:0] m_axis_tdata;

  int   n_total = 0;
  int   n_bad   = 0;
  int   done_cnt = 0;
  int   tready_viol = 0;
  int   stable_viol = 0;
  bit   rnd_sink = 0;
  bit   held_v = 0;
  logic [7:0] held_d;
  int   out_q[$];
  int   last_q[$];
  int   exp_win[9] = '{20, 21, 22, 28, 29, 30, 36, 37, 38};

  crop_writer #(
    .IN_ROWS (8),
    .IN_COLS (8),
    .OUT_ROWS(3),
    .OUT_COLS(3)
  ) u_dut (
    .clk          (clk),
    .srst         (srst),
    .ap_start     (ap_start),
    .ap_ready     (ap_ready),
    .ap_idle      (ap_idle),
    .ap_done      (ap_done),
    .row_offset   (row_offset),
    .col_offset   (col_offset),
    .cfg_err      (cfg_err),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tuser (s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sink: inputs change just after the rising edge.
  always @(posedge clk) begin
    #1;
    m_axis_tready = rnd_sink ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor on the falling edge: record handshakes, stall stability and done pulses.
  always @(negedge clk) begin
    if (held_v && m_axis_tdata != held_d) stable_viol++;
    if (srst) begin
      held_v = 0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      held_v = 0;
    end else if (m_axis_tvalid) begin
      held_v = 1;
      held_d = m_axis_tdata;
    end else begin
      held_v = 0;
    end
    if (m_axis_tvalid && m_axis_tready) begin
      out_q.push_back(int'(m_axis_tdata));
      last_q.push_back(int'(m_axis_tlast));
    end
    if (ap_done) done_cnt++;
  end

  function automatic bit in_win(input int r, input int c);
    return (r >= 2) && (r < 5) && (c >= 4) && (c < 7);
  endfunction

  task automatic start(input int ro, input int co);
    ap_start   = 1'b1;
    row_offset = 3'(ro);
    col_offset = 3'(co);
    @(posedge clk);
    #1;
    ap_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic u, input bit w);
    int n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    @(negedge clk);
    forever begin
      if (s_axis_tready !== (!w || !m_axis_tvalid || m_axis_tready)) tready_viol++;
      if (s_axis_tready) break;
      n++;
      if (n > 200) begin
        check("tready_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic send_rows(input int nrows);
    for (int r = 0; r < nrows; r++)
      for (int c = 0; c < 8; c++)
        send(8'(r * 8 + c), (r == 0 && c == 0), in_win(r, c));
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 500; i++) begin
      if (done_cnt > d0) break;
      @(negedge clk);
    end
    if (done_cnt <= d0) check("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_basic(input string tag, input int garbage);
    int d0 = done_cnt;
    out_q.delete();
    last_q.delete();
    start(2, 4);
    for (int g = 0; g < garbage; g++) send(8'(100 + g), 1'b0, 1'b0);
    send_rows(8);
    wait_done(d0);
    check($sformatf("%s_len", tag), out_q.size(), 9);
    if (out_q.size() == 9) begin
      for (int i = 0; i < 9; i++) begin
        check($sformatf("%s_data%0d", tag, i), out_q[i], exp_win[i]);
        check($sformatf("%s_last%0d", tag, i), last_q[i], int'(i == 8));
      end
    end
    check($sformatf("%s_done", tag), done_cnt - d0, 1);
    check($sformatf("%s_cfg_err", tag), int'(cfg_err), 0);
    check($sformatf("%s_idle", tag), int'(ap_idle), 1);
    check($sformatf("%s_stable", tag), stable_viol, 0);
    check($sformatf("%s_tready", tag), tready_viol, 0);
  endtask

  initial begin
    int d0;
    srst = 1'b1; ap_start = 1'b0; row_offset = '0; col_offset = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tuser = 1'b0; m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    check("rst_mvalid", int'(m_axis_tvalid), 0);
    check("rst_tlast", int'(m_axis_tlast), 0);
    check("rst_tdata", int'(m_axis_tdata), 0);
    check("rst_ready", int'(ap_ready), 1);
    check("rst_idle", int'(ap_idle), 1);
    check("rst_stready", int'(s_axis_tready), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    check("rst_done", int'(ap_done), 0);

    run_basic("basic", 0);

    // Bad offsets: 6+3 > 8 rows.
    d0 = done_cnt;
    out_q.delete();
    start(6, 0);
    @(negedge clk);
    check("bad_done_pulse", int'(ap_done), 1);
    @(negedge clk);
    check("bad_done_low", int'(ap_done), 0);
    repeat (3) @(negedge clk);
    check("bad_cfg_err", int'(cfg_err), 1);
    check("bad_done_cnt", done_cnt - d0, 1);
    check("bad_no_out", out_q.size(), 0);
    check("bad_idle", int'(ap_idle), 1);
    check("bad_stready", int'(s_axis_tready), 0);

    run_basic("garbage", 5);

    rnd_sink = 1;
    run_basic("bp", 0);
    rnd_sink = 0;

    // Resync: three rows of one frame, then a fresh SOF at position (3,0).
    d0 = done_cnt;
    out_q.delete();
    last_q.delete();
    start(2, 4);
    send_rows(3);
    send_rows(8);
    wait_done(d0);
    check("rs_len", out_q.size(), 12);
    if (out_q.size() == 12) begin
      for (int i = 0; i < 3; i++) check($sformatf("rs_old%0d", i), out_q[i], exp_win[i]);
      for (int i = 0; i < 9; i++) check($sformatf("rs_new%0d", i), out_q[i + 3], exp_win[i]);
      for (int i = 0; i < 12; i++) check($sformatf("rs_last%0d", i), last_q[i], int'(i == 11));
    end
    check("rs_cfg_err", int'(cfg_err), 1);
    check("rs_done", done_cnt - d0, 1);

    // Reset after the second window pixel has been handed downstream.
    d0 = done_cnt;
    out_q.delete();
    last_q.delete();
    start(2, 4);
    for (int i = 0; i < 22; i++) send(8'(i), (i == 0), in_win(i / 8, i % 8));
    srst = 1'b1;
    @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    check("mr_mvalid", int'(m_axis_tvalid), 0);
    check("mr_tdata", int'(m_axis_tdata), 0);
    check("mr_tlast", int'(m_axis_tlast), 0);
    check("mr_idle", int'(ap_idle), 1);
    check("mr_stready", int'(s_axis_tready), 0);
    check("mr_cfg_err", int'(cfg_err), 0);
    repeat (5) @(negedge clk);
    check("mr_outs", out_q.size(), 2);
    check("mr_no_done", done_cnt - d0, 0);

    run_basic("after_rst", 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/crop_writer.md
Name: crop_writer

Overview:
- Producer-side counterpart to the normalization reader in the image pipeline.
- Accepts a full camera frame as an 8-bit AXI-Stream, with start-of-frame on tuser.
- Extracts an OUT_ROWS x OUT_COLS window at a run-time offset and streams the window pixels downstream in raster order.
- Runs one frame per ap_start, using the same ap_start/ap_ready/ap_done control style as the rest of the pipeline.

Parameters:
- IN_ROWS, 32, rows per input frame.
- IN_COLS, 32, columns per input frame.
- OUT_ROWS, 10, rows in the cropped window.
- OUT_COLS, 10, columns in the cropped window.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- srst  in  1  synchronous active-high reset.
- ap_start  in  1  start a crop of the next frame. Sampled only in IDLE.
- ap_ready  out  1  high in IDLE; block can accept ap_start.
- ap_idle  out  1  high in IDLE.
- ap_done  out  1  one-cycle pulse when the frame is finished.
- row_offset  in  $clog2(IN_ROWS)  window top row. Latched on ap_start.
- col_offset  in  $clog2(IN_COLS)  window left column. Latched on ap_start.
- cfg_err  out  1  sticky flag: bad offsets or resync. Cleared on accepted ap_start.
- s_axis_tvalid  in  1  input pixel valid.
- s_axis_tready  out  1  input pixel ready.
- s_axis_tdata  in  8  input pixel.
- s_axis_tuser  in  1  start of frame; marks pixel (0,0).
- m_axis_tvalid  out  1  output pixel valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  8  cropped pixel.
- m_axis_tlast  out  1  marks the last pixel of the window.

Behaviour:
- Reset: state=IDLE, all counters=0, cfg_err=0, ap_done=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - In IDLE, ap_ready=1, ap_idle=1, s_axis_tready=0.
  - srst mid-frame aborts the frame immediately. The output register is emptied and no ap_done is issued.
- Input beat accepted = s_axis_tvalid && s_axis_tready. Output beat accepted = m_axis_tvalid && m_axis_tready.
- IDLE, on ap_start:
  - Latch both offsets and clear cfg_err.
  - If row_offset+OUT_ROWS > IN_ROWS or col_offset+OUT_COLS > IN_COLS: set cfg_err, pulse ap_done next cycle, stay IDLE.
  - Otherwise go to WAIT_SOF.
- WAIT_SOF:
  - s_axis_tready=1; beats without tuser are dropped.
  - A beat accepted with tuser=1 is pixel (0,0): process it as in CROP and go to CROP with in_col=1 (or in_row=1, in_col=0 if IN_COLS=1).
- CROP:
  - in_row/in_col advance on every accepted input beat; in_col wraps at IN_COLS-1, then in_row increments.
  - Pixel is in the window iff row_offset <= in_row < row_offset+OUT_ROWS and col_offset <= in_col < col_offset+OUT_COLS.
  - Outside the window: s_axis_tready=1 and the pixel is discarded.
  - Inside the window: s_axis_tready = !m_axis_tvalid || m_axis_tready (single output register, full throughput, no combinational tvalid path).
  - An accepted window pixel loads m_axis_tdata on the next edge, so latency is 1 cycle. m_axis_tvalid stays high until accepted; data is held stable while stalled.
  - out_cnt counts accepted window pixels. m_axis_tlast=1 with the pixel where out_cnt = OUT_ROWS*OUT_COLS-1.
  - A tuser=1 beat at any position other than (0,0) means resync:
    - set cfg_err;
    - treat the beat as a new (0,0) and reset out_cnt;
    - an already-loaded output pixel still drains normally.
  - After accepting input (IN_ROWS-1, IN_COLS-1), go to DRAIN.
- DRAIN: s_axis_tready=0. When m_axis_tvalid=0 (or its final beat is accepted this cycle), go to IDLE and pulse ap_done for 1 cycle, coincident with re-entering IDLE.
- Simultaneous events:
  - A same-cycle output acceptance and input load is allowed; the register reloads.
  - ap_start while not in IDLE is ignored.
- Widths:
  - Counters are $clog2 of their range plus 1 bit.
  - Compare offset+size in widened arithmetic with no wrap.

Test Plan:
- Basic window: IN 8x8, OUT 3x3, offsets (2,4), pixel = row*8+col, sink always ready -> output 20,21,22,28,29,30,36,37,38; tlast only on 38; ap_done 1 cycle after the frame; cfg_err=0.
- Leading garbage: 5 beats without tuser before SOF -> all 5 dropped, output identical to the basic window case.
- Backpressure: same frame, m_axis_tready random at 50% -> same 9 values in order, data stable while stalled, no loss or duplication; s_axis_tready low only on in-window beats while the register is full.
- Bad offsets: offsets (6,0) with OUT_ROWS=3 on 8 rows -> cfg_err=1, ap_done pulse, no output, state stays IDLE.
- Resync: tuser=1 injected at (3,0) -> cfg_err=1, counters restart, last 9 outputs match the window of the new frame.
- Reset mid-frame: srst asserted after 2 outputs -> all outputs at reset values next cycle, no ap_done; the next ap_start runs cleanly.
